// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit ALU: two valid/ready
// request ports, registered ALU drive, registered result with requester ID.
module alu_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              ptr_q;
   logic              id_q;
   logic              illegal_q;
   logic              grant0;
   logic              grant1;
   logic              grant_any;
   logic              accept_ok;
   logic [DATA_W-1:0] grant_a;
   logic [DATA_W-1:0] grant_b;
   logic [OP_W-1:0]   grant_op;

   // Implemented: AND, OR, ADD, SUB, SLTU, XOR (0000-0100, 0110)
   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return (op[3] || (op[2:0] == 3'b101) || (op[2:0] == 3'b111));
   endfunction

   assign grant_any  = grant0 || grant1;
   assign grant_a    = grant1 ? req1_a  : req0_a;
   assign grant_b    = grant1 ? req1_b  : req0_b;
   assign grant_op   = grant1 ? req1_op : req0_op;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Grants open in IDLE, or in RESP on the same cycle the response is taken
   always_comb begin
      state_d   = state_q;
      grant0    = 1'b0;
      grant1    = 1'b0;
      accept_ok = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
      if (accept_ok) begin
         if (req0_valid && (!req1_valid || !ptr_q)) grant0 = 1'b1;
         else if (req1_valid)                       grant1 = 1'b1;
      end
      case (state_q)
         IDLE:    if (grant0 || grant1) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = (grant0 || grant1) ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Requester ID is held privately until EXEC so a back-to-back grant does
   // not disturb the response still on display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= 1'b0;
         id_q       <= 1'b0;
         illegal_q  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (grant_any) begin
            alu_a     <= grant_a;
            alu_b     <= grant_b;
            alu_op    <= grant_op;
            id_q      <= grant1;
            illegal_q <= op_illegal(grant_op);
            ptr_q     <= ~grant1;
         end
         if (state_q == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_err    <= illegal_q;
            rsp_result <= illegal_q ? '0 : alu_result;
            rsp_zero   <= !illegal_q && alu_zero;
         end else if ((state_q == RESP) && rsp_ready && !grant_any) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, vector table plus
// directed sequences, responses scored against a FIFO of expected results.
module tb_alu_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OP_W-1:0]   req0_op, req1_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [OP_W-1:0]   alu_op;
   logic              alu_zero;
   logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [DATA_W-1:0] rsp_result;

   alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              id;
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              err;
   } rsp_t;

   typedef struct {
      int                port;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] res;
      logic              zero;
      logic              err;
   } vec_t;

   rsp_t sb[$];
   int   grant_log[$];
   int   rsp_cyc[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   logic stale = 1'b0;
   logic mon_hs;
   rsp_t mon_e;
   vec_t tbl[11];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic ref_illegal(input logic [OP_W-1:0] op);
      return !(op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd4 || op == 4'd6);
   endfunction

   function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a - b;
         4'd4:    return {31'd0, (a < b)};
         4'd6:    return a ^ b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // External ALU; the zero flag is forced high on unimplemented codes so a
   // missed error-path clear is visible.
   always_comb begin
      alu_result = ref_alu(alu_op, alu_a, alu_b);
      alu_zero   = (alu_result == '0) || ref_illegal(alu_op);
   end

   function automatic rsp_t model(input int port, input logic [OP_W-1:0] op,
                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      rsp_t r;
      r.id = 1'(port);
      if (ref_illegal(op)) begin
         r.result = '0; r.zero = 1'b0; r.err = 1'b1;
      end else begin
         r.result = ref_alu(op, a, b);
         r.zero   = (r.result == '0);
         r.err    = 1'b0;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int port, input logic v, input logic [OP_W-1:0] op,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (port == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // Present a request, wait for the grant, log the expected response.
   task automatic issue(input int port, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input rsp_t exp);
      int t = 0;
      drive_req(port, 1'b1, op, a, b);
      @(negedge clk);
      while (!(port == 0 ? req0_ready : req1_ready) && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (t >= 60) begin
         chk("ready_timeout", 32'(t), 32'd0);
         drive_req(port, 1'b0, '0, '0, '0);
      end else begin
         sb.push_back(exp);
         grant_log.push_back(port);
         last_acc = cyc;
         @(posedge clk);
         #1;
         drive_req(port, 1'b0, '0, '0, '0);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         step(1);
         t++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
      step(2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
      chk({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
      chk({tag, "_rsp_result"}, rsp_result,      32'd0);
      chk({tag, "_rsp_zero"},   32'(rsp_zero),   32'd0);
      chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
      chk({tag, "_alu_a"},      alu_a,           32'd0);
      chk({tag, "_alu_b"},      alu_b,           32'd0);
      chk({tag, "_alu_op"},     32'(alu_op),     32'd0);
      chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
      chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
   endtask

   // A response counts once; after a handshake the next cycle shows either
   // an idle port or the old response while the next op executes.
   always @(negedge clk) begin
      if (!rst_n) begin
         stale = 1'b0;
      end else begin
         mon_hs = rsp_valid && rsp_ready;
         if (mon_hs && !stale) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_result), 32'hFFFF_FFFF);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_id",     32'(rsp_id),   32'(mon_e.id));
               chk("rsp_result", rsp_result,    mon_e.result);
               chk("rsp_zero",   32'(rsp_zero), 32'(mon_e.zero));
               chk("rsp_err",    32'(rsp_err),  32'(mon_e.err));
            end
            rsp_cyc.push_back(cyc);
         end
         stale = mon_hs && !stale;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0, 4'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0};
      tbl[1]  = '{1, 4'h1, 32'h0000_000A, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0};
      tbl[2]  = '{0, 4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      tbl[3]  = '{1, 4'h3, 32'd10,        32'd3,        32'd7,         1'b0, 1'b0};
      tbl[4]  = '{0, 4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      tbl[5]  = '{1, 4'h4, 32'd2,         32'd9,        32'd1,         1'b0, 1'b0};
      tbl[6]  = '{0, 4'h6, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
      tbl[7]  = '{0, 4'h7, 32'd1,         32'd1,        32'd0,         1'b0, 1'b1};
      tbl[8]  = '{1, 4'h5, 32'd4,         32'd4,        32'd0,         1'b0, 1'b1};
      tbl[9]  = '{0, 4'h8, 32'd6,         32'd2,        32'd0,         1'b0, 1'b1};
      tbl[10] = '{1, 4'h3, 32'd3,         32'd10,       32'hFFFF_FFF9, 1'b0, 1'b0};

      drive_req(0, 1'b0, '0, '0, '0);
      drive_req(1, 1'b0, '0, '0, '0);
      rsp_ready = 1'b1;
      rst_n = 1'b0;
      step(3);
      chk_all_zero("por");
      rst_n = 1'b1;
      step(1);

      // Vector table, single requests
      for (int i = 0; i < 11; i++) begin
         rsp_t e;
         e.id = 1'(tbl[i].port); e.result = tbl[i].res; e.zero = tbl[i].zero; e.err = tbl[i].err;
         issue(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, e);
      end
      drain();

      // Reset while an op is in EXEC: op dropped, outputs cleared
      issue(0, 4'h2, 32'd5, 32'd7, model(0, 4'h2, 32'd5, 32'd7));
      rst_n = 1'b0;
      sb.delete();
      step(2);
      chk_all_zero("midreset");
      rst_n = 1'b1;
      step(4);
      chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      issue(0, 4'h2, 32'd5, 32'd7, '{1'b0, 32'd12, 1'b0, 1'b0});
      drain();
      chk("latency", 32'(rsp_cyc[rsp_cyc.size()-1] - last_acc), 32'd2);

      // Contention from a fresh pointer: 0 then 1, and 0 again
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
      grant_log.delete();
      fork
         issue(0, 4'h3, 32'd10, 32'd3, model(0, 4'h3, 32'd10, 32'd3));
         issue(1, 4'h6, 32'hF0, 32'h0F, '{1'b1, 32'hFF, 1'b0, 1'b0});
      join
      fork
         issue(0, 4'h2, 32'd1, 32'd2, model(0, 4'h2, 32'd1, 32'd2));
         issue(1, 4'h0, 32'h3C, 32'h0F, model(1, 4'h0, 32'h3C, 32'h0F));
      join
      drain();
      chk("grant_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         chk("grant_order0", 32'(grant_log[0]), 32'd0);
         chk("grant_order1", 32'(grant_log[1]), 32'd1);
         chk("grant_order2", 32'(grant_log[2]), 32'd0);
         chk("grant_order3", 32'(grant_log[3]), 32'd1);
      end

      // Port 1 streaming with rsp_ready held: one response every 2 cycles
      rsp_cyc.delete();
      for (int i = 0; i < 4; i++)
         issue(1, 4'h2, 32'(i * 100), 32'd7, model(1, 4'h2, 32'(i * 100), 32'd7));
      drain();
      chk("stream_rsps", 32'(rsp_cyc.size()), 32'd4);
      if (rsp_cyc.size() == 4)
         for (int i = 0; i < 3; i++)
            chk("stream_gap", 32'(rsp_cyc[i+1] - rsp_cyc[i]), 32'd2);

      // Backpressure; a request raised and withdrawn meanwhile has no effect
      rsp_ready = 1'b0;
      issue(0, 4'h1, 32'hA, 32'h5, '{1'b0, 32'hF, 1'b0, 1'b0});
      step(1);
      drive_req(1, 1'b1, 4'h4, 32'd2, 32'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",  32'(rsp_valid),  32'd1);
         chk("bp_result", rsp_result,      32'hF);
         chk("bp_ready0", 32'(req0_ready), 32'd0);
         chk("bp_ready1", 32'(req1_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      drive_req(1, 1'b0, '0, '0, '0);
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_released", 32'(rsp_valid), 32'd0);
      chk("bp_popped", 32'(sb.size()), 32'd0);
      step(1);

      // Illegal op followed by legal ones, including unsigned SLT
      issue(0, 4'h7, 32'd1, 32'd1, '{1'b0, 32'd0, 1'b0, 1'b1});
      issue(1, 4'h4, 32'd2, 32'd9, '{1'b1, 32'd1, 1'b0, 1'b0});
      issue(0, 4'h4, 32'hFFFF_FFFF, 32'd1, '{1'b0, 32'd0, 1'b1, 1'b0});
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
